fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Control stage directly upstream of the 8x32 register file in the FIFO.
- Turns producer/consumer requests (wr_en, rd_en) into register-file write address, write enable and read address.
- Keeps head/tail pointers and occupancy count.
- Reports full/empty status and per-request acknowledge/error handshakes.
- Data never passes through this block: wData goes straight to the register file, and the register file's rData goes straight to the consumer.

Parameters:
- ADDR_W, 3, pointer/address width; must match register-file address width.
- DEPTH, 8, entry count; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  producer write request for this cycle.
- rd_en  input  1  consumer read request for this cycle.
- wAddr  output  ADDR_W  register-file write address (= tail).
- we  output  1  register-file write enable.
- rAddr  output  ADDR_W  register-file read address (= head).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- data_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- wr_ack  output  1  registered; previous cycle's write accepted.
- wr_err  output  1  registered; previous cycle's write refused (full).
- rd_ack  output  1  registered; previous cycle's read accepted.
- rd_err  output  1  registered; previous cycle's read refused (empty).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- On reset assertion, immediately and regardless of clk:
  - head = 0, tail = 0, count = 0.
  - state = INIT.
  - wr_ack = wr_err = rd_ack = rd_err = 0.
  - Hence empty = 1, full = 0, we = 0, wAddr = 0, rAddr = 0.
- Reset mid-operation discards all pointers and occupancy. Register-file contents are not cleared but are unreachable.
- Request decode, evaluated each cycle from the current count:
  - wr_en & ~rd_en & ~full -> WRITE.
  - wr_en & ~rd_en & full -> WR_ERROR.
  - rd_en & ~wr_en & ~empty -> READ.
  - rd_en & ~wr_en & empty -> RD_ERROR.
  - Both wr_en and rd_en high, or both low -> NO_OP. Simultaneous requests are rejected, and neither ack nor err is raised.
- State register: holds the decoded operation of the previous cycle. Encodings are INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR.
  - INIT is left on the first edge after reset deassertion.
  - Acks and errors are decodes of the state register:
    - wr_ack = (state == WRITE); wr_err = (state == WR_ERROR).
    - rd_ack = (state == READ); rd_err = (state == RD_ERROR).
  - Handshake latency is therefore exactly 1 cycle after the request cycle.
- Write path:
  - we = combinational (decoded op == WRITE).
  - wAddr = tail. The register file captures wData at tail on the same edge.
  - On that edge, tail <= tail+1 and count <= count+1.
- Read path:
  - rAddr = head, combinational. The register file's rData is valid during the request cycle, and the consumer samples it in that cycle.
  - On the edge, head <= head+1 and count <= count-1.
- Arithmetic and status:
  - Pointers wrap modulo DEPTH (natural ADDR_W-bit overflow, 7 -> 0).
  - count is ADDR_W+1 bits and never leaves 0..DEPTH.
  - full, empty and data_count are combinational from count.
- Error and no-op cycles: pointers and count hold, and we = 0.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined: adds outputs almost_full (count >= DEPTH-1) and almost_empty (count <= 1). Both are combinational, and both read as 0/1 respectively under reset.
- Undefined: these ports do not exist. All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg holds:
  - State encoding constants INIT/NO_OP/WRITE/WR_ERROR/READ/RD_ERROR (3-bit).
  - ADDR_W and DEPTH defaults.
- One sub-module, fifo_ns_logic: purely combinational. Maps (wr_en, rd_en, count) to the next state. It is reused for both the state register and the pointer-update enables.
- Pointer/count registers and output decode live in fifo_ctrl.

Test Plan:
- Reset during traffic: assert reset mid-burst with count = 5 -> same-cycle count = 0, empty = 1, we = 0, all acks = 0, wAddr = rAddr = 0.
- Fill: 8 consecutive wr_en cycles from empty -> wAddr 0..7, we = 1 each cycle, wr_ack = 1 one cycle later, data_count = 8, full = 1. A 9th write -> we = 0, wr_err = 1 next cycle, count stays 8.
- Drain: 8 rd_en cycles -> rAddr 0..7, data_count 8..0, empty = 1. A 9th read -> rd_err = 1, head unchanged.
- Wrap: write 6, read 6, write 4 -> wAddr sequence 6, 7, 0, 1; rAddr = 6; data_count = 4.
- Simultaneous: wr_en = rd_en = 1 at count = 3 -> we = 0, pointers unchanged, all four handshakes 0 next cycle.
- With FIFO_ALMOST_FLAGS_EN defined: at count 7 -> almost_full = 1, full = 0. At count 1 -> almost_empty = 1, empty = 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control stage: default geometry and the
// state encoding that records the previous cycle's decoded operation.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 3;
    localparam int FIFO_DEPTH  = 8;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_ns_logic.sv
// Combinational request decoder: maps (wr_en, rd_en, count) onto the
// operation for this cycle, shared by the state register and pointer enables.
module fifo_ns_logic
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   count,
    output state_t            next_state
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};

    // Decode exclusive requests; simultaneous or absent requests are no-ops.
    always_comb begin
        next_state = NO_OP;
        case ({wr_en, rd_en})
            2'b10:   next_state = (count == DEPTH_C) ? WR_ERROR : WRITE;
            2'b01:   next_state = (count == ZERO_C)  ? RD_ERROR : READ;
            default: next_state = NO_OP;
        endcase
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: head/tail pointers, occupancy and handshakes for an
// external register file. Optional almost_full/almost_empty via FIFO_ALMOST_FLAGS_EN.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wAddr,
    output logic              we,
    output logic [ADDR_W-1:0] rAddr,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   data_count,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] head_r;
    logic [ADDR_W-1:0] tail_r;
    logic [ADDR_W:0]   count_r;
    state_t            state_r;
    state_t            next_state_s;

    fifo_ns_logic #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ns_logic (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .count      (count_r),
        .next_state (next_state_s)
    );

    // State register and pointer/occupancy update driven by the decoded op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= INIT;
            head_r  <= {ADDR_W{1'b0}};
            tail_r  <= {ADDR_W{1'b0}};
            count_r <= {(ADDR_W+1){1'b0}};
        end else begin
            state_r <= next_state_s;
            case (next_state_s)
                WRITE: begin
                    tail_r  <= tail_r + ADDR_W'(1);
                    count_r <= count_r + (ADDR_W+1)'(1);
                end
                READ: begin
                    head_r  <= head_r + ADDR_W'(1);
                    count_r <= count_r - (ADDR_W+1)'(1);
                end
                default: begin
                    head_r  <= head_r;
                    tail_r  <= tail_r;
                    count_r <= count_r;
                end
            endcase
        end
    end

    // The write strobe is masked during reset so the register file never
    // captures while the pointers are being cleared.
    assign we         = (next_state_s == WRITE) && !reset;
    assign wAddr      = tail_r;
    assign rAddr      = head_r;
    assign full       = (count_r == DEPTH_C);
    assign empty      = (count_r == {(ADDR_W+1){1'b0}});
    assign data_count = count_r;

    assign wr_ack = (state_r == WRITE);
    assign wr_err = (state_r == WR_ERROR);
    assign rd_ack = (state_r == READ);
    assign rd_err = (state_r == RD_ERROR);

`ifdef FIFO_ALMOST_FLAGS_EN
    assign almost_full  = (count_r >= (DEPTH_C - (ADDR_W+1)'(1)));
    assign almost_empty = (count_r <= (ADDR_W+1)'(1));
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed fill/drain/wrap/collision and
// reset scenarios followed by random traffic against an occupancy model.
module tb_fifo_ctrl;

    localparam int AW = 3;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] wAddr;
    logic          we;
    logic [AW-1:0] rAddr;
    logic          full;
    logic          empty;
    logic [AW:0]   data_count;
    logic          wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic          almost_full, almost_empty;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the FIFO is a queue of slot indices; pointers are
    // slot numbers modulo DEPTH, handshakes are what the last request earned.
    int m_q[$];
    int m_head, m_tail;
    int e_wa, e_we, e_ra, e_re;

    fifo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wAddr      (wAddr),
        .we         (we),
        .rAddr      (rAddr),
        .full       (full),
        .empty      (empty),
        .data_count (data_count),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_head = 0;
        m_tail = 0;
        e_wa = 0; e_we = 0; e_ra = 0; e_re = 0;
    endtask

    task automatic check_outputs(input int exp_we);
        int cnt;
        cnt = m_q.size();
        check("we",         int'(we),         exp_we);
        check("wAddr",      int'(wAddr),      m_tail);
        check("rAddr",      int'(rAddr),      m_head);
        check("data_count", int'(data_count), cnt);
        check("full",       int'(full),       (cnt == DP) ? 1 : 0);
        check("empty",      int'(empty),      (cnt == 0) ? 1 : 0);
        check("wr_ack",     int'(wr_ack),     e_wa);
        check("wr_err",     int'(wr_err),     e_we);
        check("rd_ack",     int'(rd_ack),     e_ra);
        check("rd_err",     int'(rd_err),     e_re);
`ifdef FIFO_ALMOST_FLAGS_EN
        check("almost_full",  int'(almost_full),  (cnt >= DP - 1) ? 1 : 0);
        check("almost_empty", int'(almost_empty), (cnt <= 1) ? 1 : 0);
`endif
    endtask

    // One request cycle: drive after the falling edge, check, then advance model.
    task automatic step(input logic wr, input logic rd);
        bit do_wr, do_rd;
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        #1;
        do_wr = wr && !rd && (m_q.size() < DP);
        do_rd = rd && !wr && (m_q.size() > 0);
        check_outputs(do_wr ? 1 : 0);
        e_wa = do_wr ? 1 : 0;
        e_we = (wr && !rd && !do_wr) ? 1 : 0;
        e_ra = do_rd ? 1 : 0;
        e_re = (rd && !wr && !do_rd) ? 1 : 0;
        if (do_wr) begin
            m_q.push_back(m_tail);
            m_tail = (m_tail + 1) % DP;
        end
        if (do_rd) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % DP;
        end
    endtask

    // Assert reset away from the clock edge with requests still active,
    // check the immediate effect, then release with idle inputs.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs(0);
        @(posedge clk);
        #1;
        check_outputs(0);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        #12;
        check_outputs(0);
        @(negedge clk);
        reset = 1'b0;

        // Fill to full, then one refused write.
        for (int i = 0; i < DP; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("full_after_fill", int'(full), 1);

        // Drain to empty, then one refused read.
        for (int i = 0; i < DP; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Wrap: write 6, read 6, write 4.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("wrap_rAddr", int'(rAddr), 6);
        check("wrap_count", int'(data_count), 4);

        // Simultaneous requests at count 3.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Reset during a burst with five entries held.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        wr_en = 1'b1;
        do_reset();
        step(1'b0, 1'b0);

        // Random traffic, biased to reach both full and empty, with rare resets.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                do_reset();
            end else if ((i / 60) % 2 == 0) begin
                step(r < 65, (r >= 55) && (r < 90));
            end else begin
                step(r < 30, (r >= 20) && (r < 90));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
